// File: rtl/methane_mem_pkg.sv
// Shared types and constants for the core-side memory/IO proxy port.
// Address constants are here so the core and benches agree on the proxy map.
package methane_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_SETTLE,
    ARB_WAIT
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam logic [31:0] UART_RX_ADDR = 32'h0001_0000;
  localparam logic [31:0] UART_TX_ADDR = 32'h0001_0004;
  localparam logic [31:0] LED_ADDR     = 32'h0001_0008;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// not granted last. The pointer moves only when the caller accepts a grant.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       grant_idx_o,
  output logic       grant_valid_o
);

  logic last_q;

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) grant_idx_o = ~last_q;
    else                grant_idx_o = req_i[1];
  end

  // Reset to "m1 granted last" so m0 wins the first tie.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                last_q <= 1'b1;
    else if (accept_i && grant_valid_o)     last_q <= grant_idx_o;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the proxy's single core-side port between fetch (m0) and data (m1),
// strobing load/we for exactly one cycle and waiting on the level-type done.
module mem_port_arbiter
  import methane_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_din,
  input  logic [DATA_W-1:0] m1_din,
  input  logic [3:0]        m0_we,
  input  logic [3:0]        m1_we,
  input  logic              m0_load,
  input  logic              m1_load,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_valid,
  output logic              m1_valid,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_din,
  output logic [3:0]        c_write_enable,
  output logic              load,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              done
);

  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        we_q, we_d;
  logic              load_q, load_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              valid0_q, valid0_d, valid1_q, valid1_d;
  logic              err0_q, err0_d, err1_q, err1_d;

  logic              finish, abort;
  logic [DATA_W-1:0] result;
  logic [1:0]        eff_req;
  logic              grant_idx, grant_valid;

  // A requester still holding req during its own valid cycle has not yet
  // seen completion, so it must not be re-granted in that cycle.
  assign eff_req = {m1_req & ~valid1_q, m0_req & ~valid0_q};

  rr_pick2 u_pick (
    .clk           (clk),
    .rst           (rst),
    .req_i         (eff_req),
    .accept_i      (state_q == ARB_IDLE),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    load_d   = load_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    result   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          addr_d  = (grant_idx == REQ_DATA) ? m1_addr : m0_addr;
          din_d   = (grant_idx == REQ_DATA) ? m1_din  : m0_din;
          we_d    = (grant_idx == REQ_DATA) ? m1_we   : m0_we;
          load_d  = (grant_idx == REQ_DATA) ? m1_load : m0_load;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_SETTLE;
      end
      ARB_SETTLE: begin
        if (done) finish = 1'b1;
        else      state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (done)                                         finish = 1'b1;
        else if (TIMEOUT != 0 && cnt_q == TIMEOUT_LAST)   abort  = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (finish || abort) begin
      state_d = ARB_IDLE;
      result  = finish ? c_dout : '0;
      if (owner_q == REQ_DATA) begin
        rdata1_d = result;
        valid1_d = 1'b1;
        err1_d   = abort;
      end else begin
        rdata0_d = result;
        valid0_d = 1'b1;
        err0_d   = abort;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= REQ_FETCH;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= '0;
      load_q   <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // Strobes are gated by ISSUE so the proxy never sees a second trigger.
  assign c_addr         = addr_q;
  assign c_din          = din_q;
  assign c_write_enable = (state_q == ARB_ISSUE) ? we_q : 4'b0000;
  assign load           = (state_q == ARB_ISSUE) && load_q;
  assign m0_rdata       = rdata0_q;
  assign m1_rdata       = rdata1_q;
  assign m0_valid       = valid0_q;
  assign m1_valid       = valid1_q;
  assign m0_err         = err0_q;
  assign m1_err         = err1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one untimed instance plus a TIMEOUT=8
// instance with its own req/done lines and shared data inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, t_m0_req, t_m1_req;
  logic [31:0] m0_addr, m1_addr, m0_din, m1_din;
  logic [3:0]  m0_we, m1_we;
  logic        m0_load, m1_load;
  logic [31:0] c_dout;
  logic        done, t_done;

  logic [31:0] m0_rdata, m1_rdata, c_addr, c_din;
  logic        m0_valid, m1_valid, m0_err, m1_err, load;
  logic [3:0]  c_write_enable;

  logic [31:0] t_m0_rdata, t_m1_rdata, t_c_addr, t_c_din;
  logic        t_m0_valid, t_m1_valid, t_m0_err, t_m1_err, t_load;
  logic [3:0]  t_c_write_enable;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int bad;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_din(m0_din), .m1_din(m1_din),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_load(m0_load), .m1_load(m1_load),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_err(m0_err), .m1_err(m1_err),
    .c_addr(c_addr), .c_din(c_din), .c_write_enable(c_write_enable),
    .load(load), .c_dout(c_dout), .done(done)
  );

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .m0_req(t_m0_req), .m1_req(t_m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_din(m0_din), .m1_din(m1_din),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_load(m0_load), .m1_load(m1_load),
    .m0_rdata(t_m0_rdata), .m1_rdata(t_m1_rdata),
    .m0_valid(t_m0_valid), .m1_valid(t_m1_valid),
    .m0_err(t_m0_err), .m1_err(t_m1_err),
    .c_addr(t_c_addr), .c_din(t_c_din), .c_write_enable(t_c_write_enable),
    .load(t_load), .c_dout(c_dout), .done(t_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; t_m0_req = 0; t_m1_req = 0;
    m0_addr = 0; m1_addr = 0; m0_din = 0; m1_din = 0;
    m0_we = 0; m1_we = 0; m0_load = 0; m1_load = 0;
    c_dout = 0; done = 1'b1; t_done = 1'b1;
    tick; tick;
    check("rst_c_addr", c_addr, 32'h0);
    check("rst_strobes", {27'd0, c_write_enable, load}, 32'h0);
    check("rst_valids", {28'd0, m0_valid, m1_valid, m0_err, m1_err}, 32'h0);
    rst = 1'b0;
    tick;

    // Single m1 read with done held high.
    m1_req = 1; m1_load = 1; m1_addr = 32'h100; c_dout = 32'hDEADBEEF;
    tick;
    check("t1_issue_load", {31'd0, load}, 32'd1);
    check("t1_issue_addr", c_addr, 32'h100);
    check("t1_no_early_valid", {31'd0, m1_valid}, 32'd0);
    tick;
    check("t1_settle_load", {31'd0, load}, 32'd0);
    tick;
    check("t1_valid", {31'd0, m1_valid}, 32'd1);
    check("t1_rdata", m1_rdata, 32'hDEADBEEF);
    check("t1_m0_untouched", {m0_rdata[30:0], m0_valid}, 32'd0);
    m1_req = 0;
    tick;
    check("t1_valid_one_cycle", {31'd0, m1_valid}, 32'd0);
    check("t1_idle_load", {31'd0, load}, 32'd0);

    // Three back-to-back grants with both requesting: m0, m1, m0.
    m0_addr = 32'h200; m0_load = 1; c_dout = 32'hA5A5A5A5;
    m1_addr = 32'h300; m1_load = 1;
    m0_req = 1; m1_req = 1;
    tick;
    check("t2_g1_addr", c_addr, 32'h200);
    check("t2_g1_load", {31'd0, load}, 32'd1);
    tick;
    check("t2_g1_settle", {31'd0, load}, 32'd0);
    tick;
    check("t2_g1_valid", {30'd0, m0_valid, m1_valid}, 32'b10);
    check("t2_g1_rdata", m0_rdata, 32'hA5A5A5A5);
    check("t2_g1_idle_load", {31'd0, load}, 32'd0);
    tick;
    check("t2_g2_addr", c_addr, 32'h300);
    check("t2_g2_load", {31'd0, load}, 32'd1);
    tick;
    check("t2_g2_settle", {31'd0, load}, 32'd0);
    tick;
    check("t2_g2_valid", {30'd0, m0_valid, m1_valid}, 32'b01);
    m1_req = 0;
    tick;
    check("t2_g3_addr", c_addr, 32'h200);
    check("t2_g3_load", {31'd0, load}, 32'd1);
    tick;
    check("t2_g3_settle", {31'd0, load}, 32'd0);
    tick;
    check("t2_g3_valid", {30'd0, m0_valid, m1_valid}, 32'b10);
    m0_req = 0;
    tick;
    check("t2_done_quiet", {29'd0, m0_valid, m1_valid, load}, 32'd0);

    // m1 UART read: done drops in SETTLE, returns ~20 cycles later.
    m1_req = 1; m1_load = 1; m1_addr = 32'h0001_0000;
    tick;
    check("t3_issue_load", {31'd0, load}, 32'd1);
    check("t3_issue_addr", c_addr, 32'h0001_0000);
    done = 0;
    tick;
    check("t3_settle_load", {31'd0, load}, 32'd0);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      tick;
      if (c_addr !== 32'h0001_0000 || load !== 1'b0 || m1_valid !== 1'b0) bad++;
    end
    check("t3_wait_hold", bad, 32'd0);
    done = 1; c_dout = 32'h4100_0000;
    tick;
    check("t3_valid", {31'd0, m1_valid}, 32'd1);
    check("t3_rdata", m1_rdata, 32'h4100_0000);
    m1_req = 0;
    tick;
    check("t3_valid_once", {31'd0, m1_valid}, 32'd0);

    // m1 UART write, done low for 10 cycles.
    m1_req = 1; m1_load = 0; m1_we = 4'b0001; m1_addr = 32'h0001_0004; m1_din = 32'h5A00_0000;
    tick;
    check("t4_issue_we", {28'd0, c_write_enable}, 32'h1);
    check("t4_issue_din", c_din, 32'h5A00_0000);
    check("t4_issue_noload", {31'd0, load}, 32'd0);
    done = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (c_write_enable !== 4'b0000 || c_din !== 32'h5A00_0000 || m1_valid !== 1'b0) bad++;
    end
    check("t4_wait_hold", bad, 32'd0);
    done = 1;
    tick;
    check("t4_valid", {31'd0, m1_valid}, 32'd1);
    check("t4_din_held", c_din, 32'h5A00_0000);
    check("t4_rdata", m1_rdata, 32'h4100_0000);
    m1_req = 0; m1_we = 0;
    tick;

    // TIMEOUT=8 instance: prime rdata, then a read whose done never returns.
    t_m1_req = 1; m1_load = 1; m1_addr = 32'h100; c_dout = 32'h77;
    tick; tick; tick;
    check("t5_prime_valid", {31'd0, t_m1_valid}, 32'd1);
    check("t5_prime_rdata", t_m1_rdata, 32'h77);
    t_m1_req = 0;
    tick;
    t_m1_req = 1; m1_addr = 32'h0001_0000; t_done = 0;
    tick;
    check("t5_issue_load", {31'd0, t_load}, 32'd1);
    tick;
    tick;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (t_m1_valid !== 1'b0 || t_m1_err !== 1'b0) bad++;
    end
    check("t5_no_early_abort", bad, 32'd0);
    tick;
    check("t5_abort_valid_err", {30'd0, t_m1_valid, t_m1_err}, 32'b11);
    check("t5_abort_rdata", t_m1_rdata, 32'h0);
    check("t5_main_quiet", {31'd0, m1_valid}, 32'd0);
    t_m1_req = 0;
    tick;
    check("t5_err_once", {30'd0, t_m1_valid, t_m1_err}, 32'b00);
    t_m0_req = 1; m0_addr = 32'h40; m0_load = 1; t_done = 1; c_dout = 32'h1234_5678;
    tick;
    check("t5_next_addr", t_c_addr, 32'h40);
    check("t5_next_load", {31'd0, t_load}, 32'd1);
    tick; tick;
    check("t5_next_valid", {30'd0, t_m0_valid, t_m0_err}, 32'b10);
    check("t5_next_rdata", t_m0_rdata, 32'h1234_5678);
    t_m0_req = 0;
    tick;

    // Asynchronous reset while the untimed instance sits in WAIT.
    m1_req = 1; m1_load = 1; m1_addr = 32'h0001_0000; done = 0;
    tick; tick; tick; tick;
    check("t6_pre_rdata", m1_rdata, 32'h4100_0000);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_addr", c_addr, 32'h0);
    check("t6_rst_din", c_din, 32'h0);
    check("t6_rst_rdata", m1_rdata | m0_rdata, 32'h0);
    check("t6_rst_flags", {26'd0, c_write_enable[0], load, m0_valid, m1_valid, m0_err, m1_err}, 32'h0);
    m1_req = 0;
    tick; tick;
    check("t6_no_valid", {30'd0, m0_valid, m1_valid}, 32'd0);
    rst = 1'b0;
    m0_addr = 32'h200; m1_addr = 32'h300; m0_load = 1; m1_load = 1; done = 1;
    m0_req = 1; m1_req = 1;
    tick;
    check("t6_m0_first_addr", c_addr, 32'h200);
    tick; tick;
    check("t6_m0_first_valid", {30'd0, m0_valid, m1_valid}, 32'b10);
    m0_req = 0; m1_req = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
